// File: rtl/bcd_pkg.sv
// Shared types and default sizing for the binary-to-BCD converter.
// Holds the FSM state encoding and the default width/digit counts.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT  = 7;
  localparam int DIGITS_DEFAULT = 3;
  localparam int CNT_W_DEFAULT  = $clog2(WIDTH_DEFAULT);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: values 5..15 get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bcd_convert_7.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake and a result register that only updates on completion.
module bcd_convert_7
  import bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;

  logic [SR_W-1:0]    w_adj;
  logic [SR_W-1:0]    w_shifted;

  // The binary part passes through untouched; only the BCD nibbles are corrected.
  assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_sr [WIDTH + 4*g +: 4]),
      .o_nib (w_adj[WIDTH + 4*g +: 4])
    );
  end

  assign w_shifted = w_adj << 1;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sr    <= {{BCD_W{1'b0}}, bin_in};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_sr  <= w_shifted;
          r_cnt <= r_cnt + CNT_W'(1);
          // Last of WIDTH shifts: publish the finished digits in one step.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_bcd   <= w_shifted[SR_W-1 -: BCD_W];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bcd_convert_7.sv
// Scoreboard bench for bcd_convert_7: the driver queues expected BCD results,
// a negedge monitor pops and compares one entry per done pulse.
module tb_bcd_convert_7;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  bcd_convert_7 dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("bcd_out", int'(bcd_out), int'(e));
      end
    end
  end

  // Counts edges after the current point until done is seen (sampled #1 after edges).
  task automatic wait_done(input int budget, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!done && n < budget) begin
      if (busy) busy_cnt++;
      @(posedge CLK); #1;
      n++;
    end
  endtask

  // One directed conversion with a hand-computed expected value.
  task automatic run_one(input logic [6:0] v, input logic [11:0] exp);
    int n, bc;
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(exp);
    @(posedge CLK); #1;
    start  = 1'b0;
    bin_in = 7'($urandom);
    wait_done(20, n, bc);
    check("latency", n, 7);
    check("busy_cycles", bc, 7);
    check("busy_at_done", int'(busy), 0);
    @(posedge CLK); #1;
  endtask

  typedef struct { logic [6:0] v; logic [11:0] e; } vec_t;
  vec_t vecs[10];

  initial begin
    int n, bc;

    vecs[0] = '{7'd0,   12'h000};
    vecs[1] = '{7'd127, 12'h127};
    vecs[2] = '{7'd99,  12'h099};
    vecs[3] = '{7'd100, 12'h100};
    vecs[4] = '{7'd45,  12'h045};
    vecs[5] = '{7'd9,   12'h009};
    vecs[6] = '{7'd10,  12'h010};
    vecs[7] = '{7'd19,  12'h019};
    vecs[8] = '{7'd20,  12'h020};
    vecs[9] = '{7'd64,  12'h064};

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd",  int'(bcd_out), 0);

    foreach (vecs[i]) run_one(vecs[i].v, vecs[i].e);

    // start pulsed while busy must be ignored
    bin_in = 7'd63;
    start  = 1'b1;
    exp_q.push_back(12'h063);
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    start  = 1'b1;
    bin_in = 7'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(20, n, bc);
    check("busy_ignore_latency", n + 2, 7);
    repeat (12) @(posedge CLK);
    #1 check("busy_ignore_idle", int'(busy), 0);

    // reset during the third SHIFT cycle aborts without a done pulse
    bin_in = 7'd88;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd",  int'(bcd_out), 0);
    repeat (15) @(posedge CLK);
    #1;

    // start held high: counter-style sweep 0..127, period WIDTH+1
    bin_in = 7'd0;
    start  = 1'b1;
    exp_q.push_back(ref_bcd(0));
    @(posedge CLK); #1;
    for (int v = 1; v <= 128; v++) begin
      wait_done(20, n, bc);
      check("sweep_latency", n, 7);
      if (v < 128) begin
        bin_in = 7'(v);
        exp_q.push_back(ref_bcd(v));
        @(posedge CLK); #1;
      end else begin
        start = 1'b0;
      end
    end
    repeat (4) @(posedge CLK);
    #1 check("final_idle_busy", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_convert_7.md
Name: bcd_convert_7

Overview:
Sequential binary-to-BCD converter. It consumes the 7-bit value produced by count_7 and produces three packed BCD digits (hundreds, tens, ones) for the 7-segment display path.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock.
- Uses a start/busy/done handshake, so the counter side can sample a value and wait for the result.

Parameters:
WIDTH, 7, binary input width; the count range is 0..2^WIDTH-1.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
Clocking and reset: one clock; reset is synchronous and active-high.
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
start  input  1  request a conversion of bin_in; sampled only when the block is not busy.
bin_in  input  WIDTH  binary value to convert; captured on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse: bcd_out has just been updated.
bcd_out  output  4*DIGITS  result: [11:8] hundreds, [7:4] tens, [3:0] ones.

Behaviour:
Reset:
- When RST=1 at a rising edge: state=IDLE, busy=0, done=0, bcd_out=0, shift register and bit counter cleared.
- RST has priority over start and over any in-flight conversion. An aborted conversion produces no done pulse.

FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, load the shift register as {DIGITS*4 zeros, bin_in}, set bit counter=0, go to SHIFT. Otherwise stay in IDLE.
- SHIFT, once per edge:
  - Add-3 step: each BCD nibble of the shift register that is >=5 gets +3.
  - Shift the whole register left by 1.
  - Increment the bit counter.
  - When the counter reaches WIDTH-1 on this edge (i.e. the WIDTH-th shift), write the upper 4*DIGITS bits to bcd_out and go to DONE.
- DONE: done=1 for this cycle only.
  - If start=1, accept the new request exactly as IDLE does and go straight to SHIFT (back-to-back conversions).
  - Otherwise go to IDLE.

Handshake and latency:
- Request accepted at edge k. done goes high after edge k+WIDTH, so it is visible for one cycle.
- With default parameters, latency is 7 clocks from accept to done.
- busy=1 exactly while state==SHIFT.
- start asserted while busy is ignored: it is neither queued nor does it corrupt the result.
- bin_in may change freely after the accepting edge.

Output rules:
- bcd_out holds its last value until the next completed conversion. It never shows intermediate values.
- Arithmetic: the add-3 step operates on 4-bit nibbles with no carry between nibbles. Every digit of bcd_out is always in 0..9.

Boundary conditions:
- bin_in=0 -> 0x000.
- bin_in=2^WIDTH-1 (127) -> 0x127. No overflow is possible with the parameter constraint above.
- start held high continuously -> a new conversion starts on every DONE cycle, giving a period of WIDTH+1 clocks.

Decomposition:
Shared package (bcd_pkg) holds:
- State enum/localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- WIDTH_DEFAULT=7 and DIGITS_DEFAULT=3.
- Counter width constant: $clog2(WIDTH).

Sub-module bcd_add3:
- Combinational, 4-bit in/out: out = (in>=5) ? in+3 : in.
- Instantiated DIGITS times in a generate loop on the BCD portion of the shift register.

Test Plan:
1. Reset then start with bin_in=0 -> done pulses 7 cycles after accept, bcd_out=0x000, busy high for exactly 7 cycles.
2. start with bin_in=127 -> bcd_out=0x127. Then bin_in=99 -> 0x099. Then 100 -> 0x100. Then 45 -> 0x045.
3. Accept bin_in=63, then pulse start with bin_in=5 during busy -> single done, bcd_out=0x063, no second conversion.
4. Accept bin_in=88, assert RST at cycle 3 of SHIFT -> the next cycle shows busy=0, done=0, bcd_out=0x000, and no done pulse follows.
5. start held high, bin_in driven by a count_7 instance counting 0..127 -> each done shows bcd_out equal to the decimal of the captured value. Compare against a reference model for all 128 values; conversion period is 8 clocks.
6. Ones-digit add-3 boundary: bin_in=9 -> 0x009, bin_in=10 -> 0x010, bin_in=19 -> 0x019, bin_in=20 -> 0x020.
